// File: rtl/renkon_serial_buf_pkg.sv
// Shared constants for the renkon output serialiser bank: core count,
// data width and bank address width, plus serial_re encodings derived
// from them.
package renkon_serial_buf_pkg;

    localparam int RENKON_CORE    = 4;
    localparam int RENKON_CORELOG = 2;
    localparam int DWIDTH         = 16;
    localparam int OUTSIZE        = 4;

    // serial_re encodings: 0 is idle, 1..CORE selects bank k-1.
    localparam logic [RENKON_CORELOG:0] RE_IDLE = '0;
    localparam logic [RENKON_CORELOG:0] RE_ONE  = (RENKON_CORELOG+1)'(1);
    localparam logic [RENKON_CORELOG:0] RE_LAST = (RENKON_CORELOG+1)'(RENKON_CORE);

endpackage

// File: rtl/renkon_serial_buf_if.sv
// Bus between the renkon core controller (master) and the serialiser
// bank (slave). There is no backpressure: each out_valid word must be
// taken by the consumer in the cycle it is presented, and each serial_we
// or serial_re request is acted on at the edge where it is sampled.
interface renkon_serial_buf_if;
    import renkon_serial_buf_pkg::*;

    logic                              serial_we;
    logic [RENKON_CORELOG:0]           serial_re;
    logic [OUTSIZE-1:0]                serial_addr;
    logic [RENKON_CORE*DWIDTH-1:0]     in_data;
    logic                              out_valid;
    logic signed [DWIDTH-1:0]          out_wdata;
    logic [OUTSIZE:0]                  wr_extent;
    logic                              drain_done;
    logic                              err;

    modport master (
        output serial_we, serial_re, serial_addr, in_data,
        input  out_valid, out_wdata, wr_extent, drain_done, err
    );

    modport slave (
        input  serial_we, serial_re, serial_addr, in_data,
        output out_valid, out_wdata, wr_extent, drain_done, err
    );

endinterface

// File: rtl/renkon_serial_bank.sv
// One serialiser bank: simple dual-port RAM with one write port and one
// registered read port. A read and a write to the same address in the
// same cycle return the old contents (read-first). The read register only
// updates on a read, so it holds the last word between reads.
module renkon_serial_bank #(
    parameter int DWIDTH = 16,
    parameter int ADDRW  = 4
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              we,
    input  logic [ADDRW-1:0]  waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [ADDRW-1:0]  raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [2**ADDRW];

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; non-blocking semantics give read-first on collision.
    always_ff @(posedge clk) begin
        if (!xrst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/renkon_serial_buf.sv
// renkon_serial_buf: captures all core results in one write and drains
// them one bank at a time into a single output stream.
// Optional protocol checker enabled by defining RENKON_SERIAL_CHECK_EN;
// without it err is tied low and the datapath is unchanged.
module renkon_serial_buf
    import renkon_serial_buf_pkg::*;
(
    input logic               clk,
    input logic               xrst,
    renkon_serial_buf_if.slave bus
);

    localparam int CORE    = RENKON_CORE;
    localparam int CORELOG = RENKON_CORELOG;
    localparam int ADDRW   = OUTSIZE;

    logic                      rd_valid;
    logic                      arm;
    logic [ADDRW:0]            addr_ext;
    logic [ADDRW:0]            addr_plus1;
    logic [ADDRW:0]            wr_extent_q;
    logic [ADDRW:0]            wr_extent_d;
    logic                      out_valid_q;
    logic                      drain_done_q;
    logic [CORELOG-1:0]        sel_q;
    logic [DWIDTH-1:0]         bank_rdata [CORE];

    // Decode the read request and the drain-end condition.
    always_comb begin
        rd_valid   = (bus.serial_re != RE_IDLE) && (bus.serial_re <= RE_LAST);
        addr_ext   = {1'b0, bus.serial_addr};
        addr_plus1 = addr_ext + (ADDRW+1)'(1);
        arm        = (bus.serial_re == RE_LAST) && (wr_extent_q != '0) &&
                     (addr_ext == wr_extent_q - (ADDRW+1)'(1));
    end

    // One bank per core; all are written together, only the selected one reads.
    for (genvar c = 0; c < CORE; c++) begin : g_bank
        localparam logic [CORELOG:0] K = (CORELOG+1)'(c + 1);
        renkon_serial_bank #(
            .DWIDTH (DWIDTH),
            .ADDRW  (ADDRW)
        ) u_bank (
            .clk   (clk),
            .xrst  (xrst),
            .we    (bus.serial_we),
            .waddr (bus.serial_addr),
            .wdata (bus.in_data[c*DWIDTH +: DWIDTH]),
            .re    (bus.serial_re == K),
            .raddr (bus.serial_addr),
            .rdata (bank_rdata[c])
        );
    end

    // Extent tracker: grows with writes, cleared when a drain is armed.
    always_comb begin
        wr_extent_d = wr_extent_q;
        if (arm) begin
            wr_extent_d = '0;
        end else if (bus.serial_we && (addr_plus1 > wr_extent_q)) begin
            wr_extent_d = addr_plus1;
        end
    end

    // Output control registers; sel_q holds so out_wdata holds between reads.
    always_ff @(posedge clk) begin
        if (!xrst) begin
            wr_extent_q  <= '0;
            out_valid_q  <= 1'b0;
            drain_done_q <= 1'b0;
            sel_q        <= '0;
        end else begin
            wr_extent_q  <= wr_extent_d;
            out_valid_q  <= rd_valid;
            drain_done_q <= arm;
            if (rd_valid) begin
                sel_q <= CORELOG'(bus.serial_re - RE_ONE);
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_wdata  = bank_rdata[sel_q];
    assign bus.wr_extent  = wr_extent_q;
    assign bus.drain_done = drain_done_q;

`ifdef RENKON_SERIAL_CHECK_EN
    logic drain_seen_q;
    logic err_q;
    logic err_set;

    // Protocol violations seen this cycle.
    always_comb begin
        err_set = (bus.serial_re > RE_LAST) ||
                  (rd_valid && (addr_ext >= wr_extent_q)) ||
                  (bus.serial_we && rd_valid) ||
                  (bus.serial_we && (bus.serial_re != RE_IDLE) && drain_seen_q);
    end

    // Sticky error flag and per-batch "drain has started" tracker.
    always_ff @(posedge clk) begin
        if (!xrst) begin
            err_q        <= 1'b0;
            drain_seen_q <= 1'b0;
        end else begin
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (arm) begin
                drain_seen_q <= 1'b0;
            end else if (bus.serial_re != RE_IDLE) begin
                drain_seen_q <= 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_renkon_serial_buf.sv
// Directed bench for renkon_serial_buf with a scoreboard of expected
// output words (and their drain_done flags) popped on out_valid.
module tb_renkon_serial_buf
    import renkon_serial_buf_pkg::*;
();

    localparam int CORE = RENKON_CORE;
    localparam int DW   = DWIDTH;
    localparam int AW   = OUTSIZE;
`ifdef RENKON_SERIAL_CHECK_EN
    localparam logic [31:0] ERR_EXP = 32'd1;
`else
    localparam logic [31:0] ERR_EXP = 32'd0;
`endif

    logic clk;
    logic xrst;

    renkon_serial_buf_if bus();

    renkon_serial_buf dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    int n_cmp;
    int n_fail;
    int n_done;

    logic [DW-1:0] exp_q[$];
    logic          done_q[$];
    logic [DW-1:0] model [CORE][2**AW];

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [CORE*DW-1:0] pack(input int a);
        logic [CORE*DW-1:0] d;
        d = '0;
        for (int c = 0; c < CORE; c++) d[c*DW +: DW] = DW'(c*100 + a);
        return d;
    endfunction

    function automatic logic [CORE*DW-1:0] fill(input int v);
        logic [CORE*DW-1:0] d;
        d = '0;
        for (int c = 0; c < CORE; c++) d[c*DW +: DW] = DW'(v);
        return d;
    endfunction

    // One clock of stimulus; pushes the expected read word before the edge.
    task automatic drive(input bit we, input int re, input int addr,
                         input logic [CORE*DW-1:0] data, input bit exp_done);
        bus.serial_we   = we;
        bus.serial_re   = (RENKON_CORELOG+1)'(re);
        bus.serial_addr = AW'(addr);
        bus.in_data     = data;
        if (re >= 1 && re <= CORE) begin
            exp_q.push_back(model[re-1][addr]);
            done_q.push_back(exp_done);
        end
        if (we) begin
            for (int c = 0; c < CORE; c++) model[c][addr] = data[c*DW +: DW];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, '0, 1'b0);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        logic          d;
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                d = done_q.pop_front();
                check("out_wdata", 32'(DW'(bus.out_wdata)), 32'(e));
                check("drain_done_with_word", 32'(bus.drain_done), 32'(d));
                if (bus.drain_done === 1'b1) n_done++;
            end
        end else begin
            check("drain_done_idle", 32'(bus.drain_done), 32'd0);
        end
    end

    initial begin
        n_cmp = 0; n_fail = 0; n_done = 0;
        for (int c = 0; c < CORE; c++)
            for (int a = 0; a < 2**AW; a++) model[c][a] = '0;

        // 1: reset with random inputs
        xrst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.serial_we   = 1'($urandom_range(0, 1));
            bus.serial_re   = (RENKON_CORELOG+1)'($urandom_range(0, 7));
            bus.serial_addr = AW'($urandom_range(0, 2**AW-1));
            bus.in_data     = {$urandom, $urandom};
            @(posedge clk);
            #1;
            check("rst_out_valid",  32'(bus.out_valid), 32'd0);
            check("rst_out_wdata",  32'(DW'(bus.out_wdata)), 32'd0);
            check("rst_wr_extent",  32'(bus.wr_extent), 32'd0);
            check("rst_drain_done", 32'(bus.drain_done), 32'd0);
            check("rst_err",        32'(bus.err), 32'd0);
        end
        xrst = 1'b1;
        idle();

        // 2: write 0..7, drain all four banks
        for (int a = 0; a < 8; a++) drive(1'b1, 0, a, pack(a), 1'b0);
        check("t2_extent_full", 32'(bus.wr_extent), 32'd8);
        for (int k = 1; k <= CORE; k++)
            for (int a = 0; a < 8; a++) drive(1'b0, k, a, '0, (k == CORE) && (a == 7));
        check("t2_extent_cleared", 32'(bus.wr_extent), 32'd0);
        idle();
        check("t2_done_count", 32'(n_done), 32'd1);

        // 3: sparse write sets extent, single-word drain
        drive(1'b1, 0, 5, pack(5), 1'b0);
        check("t3_extent_6", 32'(bus.wr_extent), 32'd6);
        drive(1'b0, CORE, 5, '0, 1'b1);
        check("t3_extent_cleared", 32'(bus.wr_extent), 32'd0);
        drive(1'b1, 0, 2, pack(2), 1'b0);
        check("t3_extent_3", 32'(bus.wr_extent), 32'd3);
        idle();
        check("t3_done_count", 32'(n_done), 32'd2);
        check("t3_err_clean", 32'(bus.err), 32'd0);

        // 4: read-first collision
        drive(1'b1, 0, 3, fill(11), 1'b0);
        drive(1'b1, 1, 3, fill(22), 1'b0);
        check("t4_collision_word", 32'(DW'(bus.out_wdata)), 32'd11);
        drive(1'b0, 1, 3, '0, 1'b0);
        check("t4_after_word", 32'(DW'(bus.out_wdata)), 32'd22);
        idle();
        check("t4_err", 32'(bus.err), ERR_EXP);
        idle();
        check("t4_err_sticky", 32'(bus.err), ERR_EXP);

        // 5: out-of-range bank select
        drive(1'b0, CORE+1, 3, '0, 1'b0);
        check("t5_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_out_hold", 32'(DW'(bus.out_wdata)), 32'd22);
        check("t5_err", 32'(bus.err), ERR_EXP);
        idle();

        // 6: reset in the middle of a drain
        for (int a = 0; a < 8; a++) drive(1'b1, 0, a, pack(a + 40), 1'b0);
        check("t6_extent_full", 32'(bus.wr_extent), 32'd8);
        for (int a = 0; a < 8; a++) drive(1'b0, 1, a, '0, 1'b0);
        for (int a = 0; a < 4; a++) drive(1'b0, 2, a, '0, 1'b0);
        xrst = 1'b0;
        bus.serial_we   = 1'b0;
        bus.serial_re   = (RENKON_CORELOG+1)'(2);
        bus.serial_addr = AW'(4);
        @(posedge clk);
        #1;
        check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_done",  32'(bus.drain_done), 32'd0);
        xrst = 1'b1;
        idle();
        check("t6_extent_zero", 32'(bus.wr_extent), 32'd0);
        check("t6_out_valid",   32'(bus.out_valid), 32'd0);
        check("t6_err_cleared", 32'(bus.err), 32'd0);
        idle();
        idle();

        check("final_done_count", 32'(n_done), 32'd2);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
